wm_control_panel: RTL and testbench
===================================

Name: wm_control_panel

Overview:
- Front-panel input stage directly upstream of the washing-machine controller.
- Debounces raw pushbuttons, latches the wash-option selections, and drives that controller's start, double_wash, dry_wash and time_pause inputs.
- Tracks cycle completion from the controller's done output.
- Provides status LEDs and an acknowledge-timeout flag.

Parameters:
- DEB_CYCLES, 20000: consecutive stable cycles before a debounced button level changes.
- START_HOLD, 2: minimum cycles start is held high.
- ARM_TIMEOUT, 16: maximum cycles in ARM waiting for the controller to acknowledge (done low) before abort.

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: asynchronous active-high reset.
- btn_start, input, 1: raw start button, asynchronous, bouncy.
- btn_pause, input, 1: raw pause/resume button.
- btn_double, input, 1: raw double-wash select button.
- btn_dry, input, 1: raw dry-wash select button.
- done, input, 1: controller's done output.
- start, output, 1: to controller start.
- double_wash, output, 1: to controller double_wash.
- dry_wash, output, 1: to controller dry_wash.
- time_pause, output, 1: to controller time_pause.
- led_running, output, 1: high in ARM, RUN or PAUSED.
- led_paused, output, 1: high in PAUSED.
- ack_timeout, output, 1: one-cycle pulse on ARM abort.

Behaviour:
- Reset (async assert, sync release): all outputs 0, state IDLE, both selections 0, synchronisers/debounce levels/counters 0.
- Per button debounce:
  - 2-flop synchroniser feeds a counter.
  - Counter increments while sync != deb and clears when equal.
  - When counter reaches DEB_CYCLES-1 and still differs, deb takes sync on the next edge and the counter clears.
  - With raw stable, deb changes DEB_CYCLES+2 edges after raw changes.
  - Glitches shorter than DEB_CYCLES cycles are rejected.
- Press event = deb & ~deb_q (one cycle per press). The FSM acts on it at the next edge. Releases generate nothing.
- Selection latches, updated in IDLE only; presses outside IDLE are ignored:
  - double press: double_sel toggles and dry_sel clears.
  - dry press: dry_sel toggles and double_sel clears.
  - The two selections are never both 1.
- IDLE:
  - start press goes to ARM; the ARM counter is loaded to 0.
  - pause press is ignored.
- ARM:
  - start=1, dry_wash=dry_sel, double_wash=double_sel.
  - Counter increments every cycle.
  - Go to RUN when counter >= START_HOLD-1 and done==0 sampled.
  - Otherwise, when counter == ARM_TIMEOUT-1: go to IDLE, pulse ack_timeout, keep selections.
  - Pause and option presses are ignored.
- RUN:
  - start=0, double_wash=double_sel (held for whole run), dry_wash=dry_sel.
  - done==1 goes to IDLE and clears both selections.
  - Else a pause press goes to PAUSED.
  - done has priority over a simultaneous pause press; that press is dropped.
- PAUSED:
  - time_pause=1; other outputs as in RUN.
  - pause press returns to RUN.
  - done is ignored; the controller cannot finish while paused.
- start presses in RUN/PAUSED are ignored.
- Outputs are registered: they change on the edge of the state transition, not combinationally from buttons.
- In IDLE: start=0, time_pause=0, double_wash=0, dry_wash=0.
- Reset asserted mid-run: all outputs drop immediately, so the controller sees start=0 and time_pause=0.

Test Plan (DEB_CYCLES=4, START_HOLD=2, ARM_TIMEOUT=16):
- Bounce rejection: btn_start toggling every 2 cycles for 20 cycles, then low -> no ARM entry, start stays 0. Then btn_start held high -> start rises 6 edges after stable-high plus 1, led_running=1.
- Start handshake: from reset (done=0), press start -> start high exactly 2 cycles, then RUN. Bench then drives done=1 -> IDLE next edge, led_running=0.
- Timeout: done held 1, press start -> start high 16 cycles, ack_timeout single pulse, state IDLE, start=0.
- Options: press double, then dry, in IDLE -> double_sel=0, dry_sel=1. Start -> dry_wash=1, double_wash=0 through RUN. Pressing double during RUN changes nothing; both clear after done.
- Pause: in RUN, press pause -> time_pause=1, led_paused=1. done pulse while paused is ignored. Press pause again -> time_pause=0. Pause press and done=1 on the same edge -> IDLE, time_pause=0.
- Reset mid-run: assert rst during PAUSED with double_sel=1 -> all outputs 0 immediately; after release, state IDLE with selections 0.

Source files
------------

// File: rtl/wm_control_panel.sv
`default_nettype none
// ============================================================================
// Module  : wm_control_panel
// Purpose : Debounced front panel driving the washing-machine controller.
// Revision: 1.0
// ============================================================================
module wm_control_panel #(
  parameter int DEB_CYCLES  = 20000,
  parameter int START_HOLD  = 2,
  parameter int ARM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_start,
  input  logic btn_pause,
  input  logic btn_double,
  input  logic btn_dry,
  input  logic done,
  output logic start,
  output logic double_wash,
  output logic dry_wash,
  output logic time_pause,
  output logic led_running,
  output logic led_paused,
  output logic ack_timeout
);

  localparam int c_deb_w   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int c_arm_w   = (ARM_TIMEOUT > 1) ? $clog2(ARM_TIMEOUT) : 1;
  localparam int c_i_start = 0;
  localparam int c_i_pause = 1;
  localparam int c_i_dbl   = 2;
  localparam int c_i_dry   = 3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARM    = 2'd1,
    S_RUN    = 2'd2,
    S_PAUSED = 2'd3
  } state_t;

  logic [3:0] raw_btn;
  logic [3:0] press;

  assign raw_btn = {btn_dry, btn_double, btn_pause, btn_start};

  for (genvar gi = 0; gi < 4; gi++) begin : g_debounce
    logic               sync1_q, sync1_d;
    logic               sync2_q, sync2_d;
    logic               deb_q, deb_d;
    logic               prev_q, prev_d;
    logic [c_deb_w-1:0] cnt_q, cnt_d;

    // The counter only runs while the synchronised level disagrees with the
    // debounced level, so any agreement restarts the stability window.
    always_comb begin
      sync1_d = raw_btn[gi];
      sync2_d = sync1_q;
      prev_d  = deb_q;
      deb_d   = deb_q;
      cnt_d   = '0;
      if (sync2_q != deb_q) begin
        if (cnt_q == c_deb_w'(DEB_CYCLES - 1)) begin
          deb_d = sync2_q;
        end else begin
          cnt_d = cnt_q + c_deb_w'(1);
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
        deb_q   <= 1'b0;
        prev_q  <= 1'b0;
        cnt_q   <= '0;
      end else begin
        sync1_q <= sync1_d;
        sync2_q <= sync2_d;
        deb_q   <= deb_d;
        prev_q  <= prev_d;
        cnt_q   <= cnt_d;
      end
    end

    assign press[gi] = deb_q & ~prev_q;
  end

  state_t             state_q, state_d;
  logic [c_arm_w-1:0] arm_cnt_q, arm_cnt_d;
  logic               double_sel_q, double_sel_d;
  logic               dry_sel_q, dry_sel_d;
  logic               start_q, start_d;
  logic               double_wash_q, double_wash_d;
  logic               dry_wash_q, dry_wash_d;
  logic               time_pause_q, time_pause_d;
  logic               led_running_q, led_running_d;
  logic               led_paused_q, led_paused_d;
  logic               ack_timeout_q, ack_timeout_d;

  always_comb begin
    state_d       = state_q;
    arm_cnt_d     = arm_cnt_q;
    double_sel_d  = double_sel_q;
    dry_sel_d     = dry_sel_q;
    ack_timeout_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (press[c_i_dbl]) begin
          double_sel_d = ~double_sel_q;
          dry_sel_d    = 1'b0;
        end else if (press[c_i_dry]) begin
          dry_sel_d    = ~dry_sel_q;
          double_sel_d = 1'b0;
        end
        if (press[c_i_start]) begin
          state_d   = S_ARM;
          arm_cnt_d = '0;
        end
      end
      S_ARM: begin
        if ((arm_cnt_q >= c_arm_w'(START_HOLD - 1)) && !done) begin
          state_d = S_RUN;
        end else if (arm_cnt_q == c_arm_w'(ARM_TIMEOUT - 1)) begin
          state_d       = S_IDLE;
          ack_timeout_d = 1'b1;
        end else begin
          arm_cnt_d = arm_cnt_q + c_arm_w'(1);
        end
      end
      S_RUN: begin
        // done wins over a same-cycle pause press, which is simply dropped.
        if (done) begin
          state_d      = S_IDLE;
          double_sel_d = 1'b0;
          dry_sel_d    = 1'b0;
        end else if (press[c_i_pause]) begin
          state_d = S_PAUSED;
        end
      end
      S_PAUSED: begin
        if (press[c_i_pause]) begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase

    start_d       = (state_d == S_ARM);
    double_wash_d = (state_d != S_IDLE) & double_sel_d;
    dry_wash_d    = (state_d != S_IDLE) & dry_sel_d;
    time_pause_d  = (state_d == S_PAUSED);
    led_running_d = (state_d != S_IDLE);
    led_paused_d  = (state_d == S_PAUSED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      arm_cnt_q     <= '0;
      double_sel_q  <= 1'b0;
      dry_sel_q     <= 1'b0;
      start_q       <= 1'b0;
      double_wash_q <= 1'b0;
      dry_wash_q    <= 1'b0;
      time_pause_q  <= 1'b0;
      led_running_q <= 1'b0;
      led_paused_q  <= 1'b0;
      ack_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      arm_cnt_q     <= arm_cnt_d;
      double_sel_q  <= double_sel_d;
      dry_sel_q     <= dry_sel_d;
      start_q       <= start_d;
      double_wash_q <= double_wash_d;
      dry_wash_q    <= dry_wash_d;
      time_pause_q  <= time_pause_d;
      led_running_q <= led_running_d;
      led_paused_q  <= led_paused_d;
      ack_timeout_q <= ack_timeout_d;
    end
  end

  assign start       = start_q;
  assign double_wash = double_wash_q;
  assign dry_wash    = dry_wash_q;
  assign time_pause  = time_pause_q;
  assign led_running = led_running_q;
  assign led_paused  = led_paused_q;
  assign ack_timeout = ack_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_wm_control_panel.sv
`default_nettype none
// ============================================================================
// Module  : tb_wm_control_panel
// Purpose : Directed scoreboard bench for wm_control_panel (DEB_CYCLES=4).
// Revision: 1.0
// ============================================================================
module tb_wm_control_panel;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn;   // {dry, double, pause, start}
  logic       done;
  logic       start, double_wash, dry_wash, time_pause;
  logic       led_running, led_paused, ack_timeout;
  logic [6:0] outs;

  typedef struct {
    string      tag;
    logic [6:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  wm_control_panel #(
    .DEB_CYCLES (4),
    .START_HOLD (2),
    .ARM_TIMEOUT(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_start  (btn[0]),
    .btn_pause  (btn[1]),
    .btn_double (btn[2]),
    .btn_dry    (btn[3]),
    .done       (done),
    .start      (start),
    .double_wash(double_wash),
    .dry_wash   (dry_wash),
    .time_pause (time_pause),
    .led_running(led_running),
    .led_paused (led_paused),
    .ack_timeout(ack_timeout)
  );

  // {start, double_wash, dry_wash, time_pause, led_running, led_paused, ack_timeout}
  assign outs = {start, double_wash, dry_wash, time_pause, led_running, led_paused, ack_timeout};

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ex(input string tag, input logic [6:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic chk();
    exp_t e;
    n_assert++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: observed %b required an expectation", outs);
    end else begin
      e = sb.pop_front();
      assert (outs === e.val) else begin
        n_fail++;
        $error("FAIL %s: observed %b expected %b", e.tag, outs, e.val);
      end
    end
  endtask

  // Raw level high long enough for the FSM to act (edge 7), then released.
  task automatic press(input int b);
    btn[b] = 1'b1;
    tick(7);
    btn[b] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    rst  = 1'b1;
    btn  = '0;
    done = 1'b0;
    ex("reset_hold", 7'b0000000);
    tick(2);
    chk();
    rst = 1'b0;
    tick(1);
    ex("idle_after_reset", 7'b0000000);
    chk();

    // Bounce rejection, then a clean held press
    for (int i = 0; i < 10; i++) begin
      btn[0] = ~btn[0];
      tick(2);
    end
    btn[0] = 1'b0;
    ex("bounce_rejected", 7'b0000000);
    tick(8);
    chk();
    btn[0] = 1'b1;
    ex("stable_no_early_arm", 7'b0000000);
    tick(6);
    chk();
    ex("stable_arm", 7'b1000100);
    tick(1);
    chk();
    ex("stable_arm_hold", 7'b1000100);
    tick(1);
    chk();
    ex("stable_run", 7'b0000100);
    tick(1);
    chk();
    btn[0] = 1'b0;
    tick(8);
    done = 1'b1;
    ex("stable_done_idle", 7'b0000000);
    tick(1);
    chk();
    done = 1'b0;
    tick(2);

    // Start handshake from reset
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);
    ex("hs_arm", 7'b1000100);
    press(0);
    chk();
    ex("hs_hold", 7'b1000100);
    tick(1);
    chk();
    ex("hs_run", 7'b0000100);
    tick(1);
    chk();
    done = 1'b1;
    ex("hs_done_idle", 7'b0000000);
    tick(1);
    chk();
    done = 1'b0;
    tick(8);

    // Acknowledge timeout
    done = 1'b1;
    ex("to_arm", 7'b1000100);
    press(0);
    chk();
    for (int k = 1; k < 16; k++) begin
      ex("to_hold", 7'b1000100);
      tick(1);
      chk();
    end
    ex("to_abort_pulse", 7'b0000001);
    tick(1);
    chk();
    ex("to_idle", 7'b0000000);
    tick(1);
    chk();
    done = 1'b0;
    tick(4);

    // Option selection
    press(2);
    tick(8);
    press(3);
    tick(8);
    ex("opt_arm_dry", 7'b1010100);
    press(0);
    chk();
    ex("opt_hold_dry", 7'b1010100);
    tick(1);
    chk();
    ex("opt_run_dry", 7'b0010100);
    tick(1);
    chk();
    tick(8);
    ex("opt_double_ignored_in_run", 7'b0010100);
    press(2);
    chk();
    tick(8);
    done = 1'b1;
    ex("opt_done_idle", 7'b0000000);
    tick(1);
    chk();
    done = 1'b0;
    tick(1);
    ex("opt_cleared_arm", 7'b1000100);
    press(0);
    chk();
    ex("opt_cleared_run", 7'b0000100);
    tick(2);
    chk();
    tick(8);
    done = 1'b1;
    ex("opt_cleared_idle", 7'b0000000);
    tick(1);
    chk();
    done = 1'b0;
    tick(2);

    // Pause / resume
    ex("pause_in_idle_ignored", 7'b0000000);
    press(1);
    chk();
    tick(8);
    ex("p_arm", 7'b1000100);
    press(0);
    chk();
    ex("p_run", 7'b0000100);
    tick(2);
    chk();
    tick(8);
    ex("p_paused", 7'b0001110);
    press(1);
    chk();
    tick(8);
    done = 1'b1;
    ex("p_done_ignored", 7'b0001110);
    tick(1);
    chk();
    done = 1'b0;
    tick(1);
    ex("p_resume", 7'b0000100);
    press(1);
    chk();
    tick(8);
    ex("p_pause_and_done", 7'b0000000);
    btn[1] = 1'b1;
    tick(6);
    done = 1'b1;
    tick(1);
    chk();
    done   = 1'b0;
    btn[1] = 1'b0;
    tick(8);

    // Reset while paused with double selected
    press(2);
    tick(8);
    ex("r_arm_double", 7'b1100100);
    press(0);
    chk();
    ex("r_run_double", 7'b0100100);
    tick(2);
    chk();
    tick(8);
    ex("r_paused_double", 7'b0101110);
    press(1);
    chk();
    tick(3);
    rst = 1'b1;
    #1;
    ex("r_async_drop", 7'b0000000);
    chk();
    tick(1);
    rst = 1'b0;
    tick(1);
    ex("r_idle_after", 7'b0000000);
    chk();
    ex("r_sel_cleared_arm", 7'b1000100);
    press(0);
    chk();
    ex("r_sel_cleared_run", 7'b0000100);
    tick(2);
    chk();
    done = 1'b1;
    ex("r_final_idle", 7'b0000000);
    tick(1);
    chk();
    done = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
